// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the four-digit seven-segment scan controller.
// All segment and anode encodings are active-low.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [0:0] {
    DRIVE,
    BLANK
  } scan_state_t;

  // Digit0 is the leftmost digit and sits on AN[3].
  function automatic logic [3:0] an_onehot(digit_idx_t idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot timer: counts ticks within a slot, splits each slot into DRIVE then BLANK,
// and advances the digit index, flagging the last tick of each full frame.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 8142,
  parameter int unsigned BLANK_TICKS     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output scan_state_t state,
  output digit_idx_t  idx,
  output logic        frame_end
);

  localparam int unsigned TW = $clog2(TICKS_PER_DIGIT);
  localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] LAST_DRIVE = TW'(TICKS_PER_DIGIT - BLANK_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  scan_state_t   state_q, state_d;
  digit_idx_t    idx_q, idx_d;
  logic          slot_end;

  assign slot_end  = (tick_q == LAST_TICK);
  assign frame_end = slot_end && (idx_q == 2'd3);

  always_comb begin
    tick_d  = tick_q + 1'b1;
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      DRIVE: if (tick_q == LAST_DRIVE) state_d = BLANK;
      BLANK: if (slot_end) state_d = DRIVE;
    endcase
    if (slot_end) begin
      tick_d = '0;
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      state_q <= DRIVE;
      idx_q   <= '0;
    end else begin
      tick_q  <= tick_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign state = state_q;
  assign idx   = idx_q;

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan controller: frame-synchronous arbitration between live game
// content and a timed overlay, frame-granular blink, per-digit enable, registered pin drive.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 8142,
  parameter int unsigned BLANK_TICKS     = 16,
  parameter int unsigned OVL_FRAMES      = 256,
  parameter int unsigned BLINK_FRAMES    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] game_segs,
  input  logic        ovl_req,
  input  logic [27:0] ovl_segs,
  output logic        ovl_ack,
  output logic        ovl_active,
  input  logic        blink_en,
  input  logic [3:0]  digit_en,
  output logic        frame_tick,
  output logic [6:0]  SEG,
  output logic [3:0]  AN
);

  localparam int unsigned CW = $clog2(OVL_FRAMES + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  scan_state_t state;
  digit_idx_t  idx;
  logic        frame_end;

  seg_scan_timer #(
    .TICKS_PER_DIGIT(TICKS_PER_DIGIT),
    .BLANK_TICKS    (BLANK_TICKS)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state),
    .idx      (idx),
    .frame_end(frame_end)
  );

  // Element [3] holds digit0, matching the 28-bit input packing.
  logic [3:0][6:0] fbuf_q, fbuf_d;
  logic [CW-1:0]   ovl_cnt_q, ovl_cnt_d;
  logic            ovl_active_q, ovl_active_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic            valid_q, valid_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            ack_c, still_active, drive;

  always_comb begin
    fbuf_d       = fbuf_q;
    ovl_cnt_d    = ovl_cnt_q;
    ovl_active_d = ovl_active_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    valid_d      = valid_q;
    ack_c        = 1'b0;
    still_active = ovl_active_q;
    if (frame_end) begin
      valid_d = 1'b1;
      if (ovl_active_q) begin
        ovl_cnt_d    = ovl_cnt_q - 1'b1;
        still_active = (ovl_cnt_d != '0);
      end
      ovl_active_d = still_active;
      // Expiry and a pending request in the same boundary chain directly into the new overlay.
      if (ovl_req && !still_active) begin
        ack_c        = 1'b1;
        ovl_active_d = 1'b1;
        ovl_cnt_d    = CW'(OVL_FRAMES);
        fbuf_d       = ovl_segs;
      end else if (!still_active) begin
        fbuf_d = game_segs;
      end
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // The buffer holds no real content until the first boundary, so that frame stays dark.
  always_comb begin
    drive = valid_q && (state == DRIVE) && digit_en[~idx] &&
            !(blink_en && !blink_on_q && !ovl_active_q);
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (drive) begin
      seg_d = fbuf_q[~idx];
      an_d  = an_onehot(idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbuf_q       <= {4{SEG_OFF}};
      ovl_cnt_q    <= '0;
      ovl_active_q <= 1'b0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      valid_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      fbuf_q       <= fbuf_d;
      ovl_cnt_q    <= ovl_cnt_d;
      ovl_active_q <= ovl_active_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      valid_q      <= valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign ovl_ack    = ack_c;
  assign ovl_active = ovl_active_q;
  assign frame_tick = frame_end;
  assign SEG        = seg_q;
  assign AN         = an_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller against a frame-level reference model.
module tb_seg_scan_controller;

  localparam int TPD   = 8;
  localparam int BLK   = 2;
  localparam int OVLF  = 2;
  localparam int BLNK  = 1;
  localparam int FRAME = 4 * TPD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [27:0] game_segs = '0;
  logic        ovl_req = 1'b0;
  logic [27:0] ovl_segs = '0;
  logic        blink_en = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic        ovl_ack, ovl_active, frame_tick;
  logic [6:0]  SEG;
  logic [3:0]  AN;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .TICKS_PER_DIGIT(TPD),
    .BLANK_TICKS    (BLK),
    .OVL_FRAMES     (OVLF),
    .BLINK_FRAMES   (BLNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .game_segs (game_segs),
    .ovl_req   (ovl_req),
    .ovl_segs  (ovl_segs),
    .ovl_ack   (ovl_ack),
    .ovl_active(ovl_active),
    .blink_en  (blink_en),
    .digit_en  (digit_en),
    .frame_tick(frame_tick),
    .SEG       (SEG),
    .AN        (AN)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: n = clock edges since reset release; frame k = n / FRAME.
  int          n;
  bit          ovl_valid;
  int          ovl_first;
  logic [27:0] content, ovl_content;
  logic [3:0]  an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic       exp_tick, exp_ack, exp_active, obs_tick, obs_ack, obs_active;
  logic [6:0] exp_seg, obs_seg;
  logic [3:0] exp_an, obs_an;

  function automatic bit active_in(int f);
    return ovl_valid && (f >= ovl_first) && (f < ovl_first + OVLF);
  endfunction

  task automatic model_reset();
    n          = 0;
    ovl_valid  = 1'b0;
    ovl_first  = 0;
    content    = {4{7'h7F}};
    exp_seg    = 7'h7F;
    exp_an     = 4'hF;
    exp_active = 1'b0;
  endtask

  // Called at a falling edge with inputs set; predicts, samples, clocks once, samples again.
  task automatic advance();
    int p, k, d, w;
    bit blanked, drv;
    logic [6:0] nseg;
    logic [3:0] nan;
    p = n % FRAME;
    k = n / FRAME;
    d = p / TPD;
    w = p % TPD;
    exp_tick = (p == FRAME - 1);
    exp_ack  = (p == FRAME - 1) && ovl_req && !active_in(k + 1);
    #1;
    obs_tick = frame_tick;
    obs_ack  = ovl_ack;
    blanked  = blink_en && !active_in(k) && (((k / BLNK) % 2) == 1);
    drv      = (w < TPD - BLK) && (k >= 1) && digit_en[3-d] && !blanked;
    nseg     = drv ? content[27-7*d -: 7] : 7'h7F;
    nan      = drv ? an_tab[d] : 4'hF;
    if (p == FRAME - 1) begin
      if (exp_ack) begin
        ovl_valid   = 1'b1;
        ovl_first   = k + 1;
        ovl_content = ovl_segs;
      end
      content = active_in(k + 1) ? ovl_content : game_segs;
    end
    @(posedge clk);
    n++;
    exp_seg    = nseg;
    exp_an     = nan;
    exp_active = active_in(n / FRAME);
    @(negedge clk);
    if (exp_ack) ovl_req = 1'b0;
    obs_seg    = SEG;
    obs_an     = AN;
    obs_active = ovl_active;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (SEG !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", SEG); end
    checks++;
    if (AN !== 4'hF) begin errors++; $display("FAIL reset_an got %b want 1111", AN); end
    checks++;
    if (ovl_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ovl_ack); end
    checks++;
    if (ovl_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", ovl_active); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int ticks = 0;
    game_segs = 28'h0204081;
    digit_en  = 4'hF;
    for (int i = 0; i < 3 * FRAME; i++) begin
      advance();
      if (obs_tick) ticks++;
      checks++;
      if ({obs_tick, obs_ack, obs_active} !== {exp_tick, exp_ack, exp_active}) begin
        errors++;
        $display("FAIL scan_ctl n=%0d tick/ack/act got %b%b%b want %b%b%b", n, obs_tick, obs_ack,
                 obs_active, exp_tick, exp_ack, exp_active);
      end
      checks++;
      if ({obs_seg, obs_an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL scan_pins n=%0d got SEG=%h AN=%b want SEG=%h AN=%b", n, obs_seg, obs_an,
                 exp_seg, exp_an);
      end
    end
    checks++;
    if (ticks !== 3) begin errors++; $display("FAIL scan_tick_count got %0d want 3", ticks); end
  endtask

  task automatic test_overlay();
    int acks = 0;
    ovl_segs = {4{7'h40}};
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (i == 10) ovl_req = 1'b1;
      advance();
      if (obs_ack) acks++;
      checks++;
      if ({obs_tick, obs_ack, obs_active} !== {exp_tick, exp_ack, exp_active}) begin
        errors++;
        $display("FAIL ovl_ctl n=%0d tick/ack/act got %b%b%b want %b%b%b", n, obs_tick, obs_ack,
                 obs_active, exp_tick, exp_ack, exp_active);
      end
      checks++;
      if ({obs_seg, obs_an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL ovl_pins n=%0d got SEG=%h AN=%b want SEG=%h AN=%b", n, obs_seg, obs_an,
                 exp_seg, exp_an);
      end
    end
    checks++;
    if (acks !== 1) begin errors++; $display("FAIL ovl_ack_count got %0d want 1", acks); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int first_n = 0;
    int gap = -1;
    bit second_sent = 1'b0;
    ovl_segs = 28'($urandom);
    ovl_req  = 1'b1;
    for (int i = 0; i < 6 * FRAME; i++) begin
      advance();
      if (obs_ack) begin
        acks++;
        if (acks == 1) first_n = n;
        if (acks == 2) gap = n - first_n;
      end
      if (acks == 1 && !second_sent && !ovl_req) begin
        ovl_req     = 1'b1;
        ovl_segs    = 28'($urandom);
        second_sent = 1'b1;
      end
      checks++;
      if ({obs_tick, obs_ack, obs_active} !== {exp_tick, exp_ack, exp_active}) begin
        errors++;
        $display("FAIL b2b_ctl n=%0d tick/ack/act got %b%b%b want %b%b%b", n, obs_tick, obs_ack,
                 obs_active, exp_tick, exp_ack, exp_active);
      end
      checks++;
      if ({obs_seg, obs_an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL b2b_pins n=%0d got SEG=%h AN=%b want SEG=%h AN=%b", n, obs_seg, obs_an,
                 exp_seg, exp_an);
      end
    end
    checks++;
    if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count got %0d want 2", acks); end
    checks++;
    if (gap !== OVLF * FRAME) begin
      errors++;
      $display("FAIL b2b_ack_gap got %0d want %0d", gap, OVLF * FRAME);
    end
    ovl_req = 1'b0;
  endtask

  task automatic test_blink();
    blink_en = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (i == 4 * FRAME) begin
        ovl_req  = 1'b1;
        ovl_segs = 28'($urandom);
      end
      advance();
      checks++;
      if ({obs_tick, obs_ack, obs_active} !== {exp_tick, exp_ack, exp_active}) begin
        errors++;
        $display("FAIL blink_ctl n=%0d tick/ack/act got %b%b%b want %b%b%b", n, obs_tick,
                 obs_ack, obs_active, exp_tick, exp_ack, exp_active);
      end
      checks++;
      if ({obs_seg, obs_an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL blink_pins n=%0d got SEG=%h AN=%b want SEG=%h AN=%b", n, obs_seg, obs_an,
                 exp_seg, exp_an);
      end
    end
    blink_en = 1'b0;
    ovl_req  = 1'b0;
  endtask

  task automatic test_digit_en();
    int bad = 0;
    digit_en = 4'b1010;
    for (int i = 0; i < 4 * FRAME; i++) begin
      advance();
      if (i >= FRAME && (obs_an == 4'b1011 || obs_an == 4'b1110)) bad++;
      checks++;
      if ({obs_seg, obs_an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL digen_pins n=%0d got SEG=%h AN=%b want SEG=%h AN=%b", n, obs_seg, obs_an,
                 exp_seg, exp_an);
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL digen_disabled_lit got %0d want 0", bad); end
    digit_en = 4'hF;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24 * FRAME; i++) begin
      if ($urandom_range(19, 0) == 0) game_segs = 28'($urandom);
      if ($urandom_range(39, 0) == 0) digit_en = 4'($urandom);
      if ($urandom_range(99, 0) == 0) blink_en = !blink_en;
      if (!ovl_req && $urandom_range(59, 0) == 0) begin
        ovl_req  = 1'b1;
        ovl_segs = 28'($urandom);
      end
      advance();
      checks++;
      if ({obs_tick, obs_ack, obs_active} !== {exp_tick, exp_ack, exp_active}) begin
        errors++;
        $display("FAIL rand_ctl n=%0d tick/ack/act got %b%b%b want %b%b%b", n, obs_tick,
                 obs_ack, obs_active, exp_tick, exp_ack, exp_active);
      end
      checks++;
      if ({obs_seg, obs_an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL rand_pins n=%0d got SEG=%h AN=%b want SEG=%h AN=%b", n, obs_seg, obs_an,
                 exp_seg, exp_an);
      end
    end
    blink_en = 1'b0;
    digit_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    ovl_req  = 1'b1;
    ovl_segs = 28'($urandom);
    for (int i = 0; i < 8 * FRAME; i++) begin
      advance();
      checks++;
      if ({obs_seg, obs_an, obs_active} !== {exp_seg, exp_an, exp_active}) begin
        errors++;
        $display("FAIL rstmid_pre n=%0d got SEG=%h AN=%b act=%b want SEG=%h AN=%b act=%b", n,
                 obs_seg, obs_an, obs_active, exp_seg, exp_an, exp_active);
      end
      if (exp_active && (n % TPD) == 3) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({SEG, AN} !== {7'h7F, 4'hF}) begin
      errors++;
      $display("FAIL rstmid_async_pins got SEG=%h AN=%b want SEG=7f AN=1111", SEG, AN);
    end
    checks++;
    if (ovl_active !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async_active got %b want 0", ovl_active);
    end
    ovl_req = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      advance();
      checks++;
      if ({obs_tick, obs_ack, obs_active} !== {exp_tick, exp_ack, exp_active}) begin
        errors++;
        $display("FAIL rstmid_ctl n=%0d tick/ack/act got %b%b%b want %b%b%b", n, obs_tick,
                 obs_ack, obs_active, exp_tick, exp_ack, exp_active);
      end
      checks++;
      if ({obs_seg, obs_an} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL rstmid_pins n=%0d got SEG=%h AN=%b want SEG=%h AN=%b", n, obs_seg, obs_an,
                 exp_seg, exp_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_overlay();
    test_back_to_back();
    test_blink();
    test_digit_en();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Sequences the four-digit, active-low seven-segment display: per-digit scan timing, anti-ghosting blank interval, per-digit enable and blink.
- Arbitrates display content between the live game source and a timed overlay requester (e.g. PASS/FAIL message).
- Content is switched only at frame boundaries, so no frame ever shows mixed sources.
- Drives SEG/AN pins directly; replaces free-running per-clock digit rotation.

Parameters:
- TICKS_PER_DIGIT, 8142, clk cycles per digit slot (DRIVE + BLANK); must be >= 2.
- BLANK_TICKS, 16, cycles at the end of each slot with all anodes off; 1 <= BLANK_TICKS < TICKS_PER_DIGIT.
- OVL_FRAMES, 256, full frames an accepted overlay stays displayed; must be >= 1.
- BLINK_FRAMES, 64, half-period of blink, in frames; must be >= 1.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset, active-low, asynchronous.
- game_segs, in, 28, live content; [27:21]=digit0 (leftmost) … [6:0]=digit3; active-low segments.
- ovl_req, in, 1, overlay request; held high until ovl_ack.
- ovl_segs, in, 28, overlay content; same packing; sampled on the ovl_ack cycle.
- ovl_ack, out, 1, one-cycle accept pulse.
- ovl_active, out, 1, overlay currently owns the frame buffer.
- blink_en, in, 1, blink game content; ignored while ovl_active.
- digit_en, in, 4, per-digit enable; [3]=digit0; sampled per slot.
- frame_tick, out, 1, one-cycle pulse at each frame boundary.
- SEG, out, 7, segment cathodes, active-low.
- AN, out, 4, anodes, active-low; digit0=4'b0111 … digit3=4'b1110.

Behaviour:
- Reset (async assert, sync release): SEG=7'h7F, AN=4'hF, ovl_ack=0, ovl_active=0, frame_tick=0. State=DRIVE, idx=0, tick=0, frame buffer=all 7'h7F, blink phase=on, counters=0.
- FSM states:
  - DRIVE: ticks 0..TICKS_PER_DIGIT-BLANK_TICKS-1.
  - BLANK: remaining BLANK_TICKS ticks.
  - DRIVE->BLANK when tick reaches TICKS_PER_DIGIT-BLANK_TICKS-1.
  - BLANK->DRIVE at the last tick of the slot; idx increments mod 4, tick clears.
- Frame boundary: last BLANK tick of idx=3. That cycle: frame_tick=1, then arbitration, then buffer latch.
- Arbitration, evaluated in order at a boundary:
  1. If ovl_active, decrement the frame count; at 0, clear ovl_active.
  2. If ovl_req and overlay now inactive: ovl_ack=1 the same cycle, capture ovl_segs, set ovl_active, load count=OVL_FRAMES. Expiry plus a pending request in the same boundary gives back-to-back overlays with no game frame between them.
  3. ovl_req while ovl_active: no ack; the request waits.
  4. Latch frame buffer: overlay capture if ovl_active (new value), else game_segs.
- Blink: phase toggles every BLINK_FRAMES boundaries. Phase=off and blink_en and !ovl_active: all four digits blanked for that frame. Phase counter runs regardless of blink_en.
- Output registers, one cycle latency from state:
  - DRIVE with digit_en[idx] set: SEG = buffer digit idx, AN = one-hot-low(idx).
  - BLANK, or digit disabled, or blink-off: SEG=7'h7F, AN=4'hF.
  - Slot timing is unchanged in every blanked case.
- Never more than one AN bit low. No AN change without an intervening all-off cycle.
- game_segs changes mid-frame take effect only at the next boundary.
- Reset mid-overlay: overlay dropped, ovl_active=0. The first frame after reset is blank, since the buffer reset value is 7'h7F.

Decomposition:
- seg_pkg: SEG_OFF=7'h7F, AN_OFF=4'hF, typedef digit_idx_t (2 bits), enum scan_state_t {DRIVE, BLANK}, function an_onehot(digit_idx_t).
- Sub-module seg_scan_timer: tick counter, DRIVE/BLANK state, idx, slot_end/frame_end strobes.
- Top holds arbitration, frame buffer, blink, output registers.

Test Plan (TICKS_PER_DIGIT=8, BLANK_TICKS=2, OVL_FRAMES=2, BLINK_FRAMES=1; frame=32 cycles):
- Reset then game_segs=28'h0204081 constant, digit_en=4'hF -> frame 1: AN stays 4'hF. Frame 2 onward: each digit 6 cycles driven then 2 cycles SEG=7F/AN=F. AN sequence 0111,1011,1101,1110. frame_tick every 32 cycles.
- ovl_req held from mid-frame, ovl_segs=all 7'h40 -> ovl_ack exactly at the next frame_tick cycle. Exactly 2 frames show 7'h40. ovl_active then falls at a boundary and game content returns.
- Second ovl_req held during an active overlay -> no ack until expiry boundary. Ack on that boundary; the following frame shows the new overlay with no game frame in between.
- blink_en=1, no overlay -> frames alternate fully blank / normal. Set ovl_req -> overlay frames never blanked.
- digit_en=4'b1010 -> digits 1 and 3 AN=F throughout their slots; digit 0/2 timing unchanged.
- Assert rst_n low mid-overlay, mid-DRIVE -> SEG=7F, AN=F, ovl_active=0 immediately, with no clk edge. After release, one blank frame, then game content.
